pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 3-stage (IF/ID, EXM, WB) RV32I core. Decides each cycle whether the PC and the pipeline registers advance, hold or are filled with a bubble. Handles load-use interlocks, redirect flushes (taken branch / JAL / JALR resolved in EXM) and whole-pipe freezes during multi-cycle memory or UART accesses. Works alongside the forwarding unit: it inserts only the bubbles that forwarding cannot cover.

## Interface

Parameters:
- LOAD_BUBBLES, default 1: bubbles inserted per load-use hazard; legal range 1–7.
- REDIRECT_FLUSH, default 1: cycles ID→EXM is bubbled after a redirect, covering synchronous IMEM/BIOS read latency; legal range 1–7.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_inst  in  32  instruction in the IF/ID stage.
- exm_inst  in  32  instruction in the ID/EXM stage.
- exm_reg_wen  in  1  EXM instruction writes rd.
- exm_is_load  in  1  EXM instruction is a load.
- exm_redirect  in  1  EXM resolved a control transfer to a non-sequential PC.
- mem_busy  in  1  data memory or MMIO is not ready; freeze the pipe.
- pc_stall  out  1  hold the PC.
- pc_redirect  out  1  PC loads the EXM target this cycle.
- if_id_stall  out  1  hold the IF/ID register.
- id_exm_bubble  out  1  load a NOP into ID/EXM.
- id_exm_stall  out  1  hold ID/EXM.
- exm_wb_stall  out  1  hold EXM/WB.
- stall_cycles  out  32  performance counter; present only with PIPECTRL_PERF_EN.

## Operation

- **rs usage decode on id_inst[6:2]:**
  - rs1 is used except for LUI 01101, AUIPC 00101, JAL 11011, and CSR-immediate (11100 with funct3[2]=1).
  - rs2 is used only for branch 11000, store 01000 and R-type 01100.
- **Load-use hazard (use_haz):** exm_is_load & exm_reg_wen & exm_inst[11:7]≠0 & (rs1 used & id_inst[19:15]==rd, or rs2 used & id_inst[24:20]==rd).
- **FSM states:** RUN, LDSTALL, FLUSH. A 3-bit down-counter cnt serves both LDSTALL and FLUSH.
- **Priority each cycle:** mem_busy > exm_redirect > use_haz.
- **mem_busy=1 (any state):**
  - Assert pc_stall, if_id_stall, id_exm_stall and exm_wb_stall.
  - Deassert id_exm_bubble and pc_redirect.
  - State and cnt hold.
- **RUN, exm_redirect:**
  - Assert pc_redirect and id_exm_bubble.
  - If REDIRECT_FLUSH>1: next state FLUSH, cnt←REDIRECT_FLUSH−2. Otherwise stay in RUN.
- **RUN, use_haz (no redirect):**
  - Assert pc_stall, if_id_stall and id_exm_bubble.
  - If LOAD_BUBBLES>1: next state LDSTALL, cnt←LOAD_BUBBLES−2.
- **LDSTALL:**
  - Outputs as for use_haz.
  - If cnt==0, go to RUN. Otherwise cnt−1.
- **FLUSH:**
  - Assert id_exm_bubble; the PC advances normally.
  - If cnt==0, go to RUN. Otherwise cnt−1.
- **exm_redirect in LDSTALL/FLUSH:** takes priority. Re-enter the redirect action and reload cnt from REDIRECT_FLUSH.
- **RUN with no event:** all outputs 0.

## Timing

- All stall, bubble and redirect outputs are combinational from state, cnt and the current inputs. Zero-cycle reaction: a hazard is bubbled in the same cycle it is visible.
- **Reset:**
  - While rst=1: state←RUN, cnt←0, stall_cycles←0.
  - Outputs during rst: id_exm_bubble=1, all others 0.
- **Load-use:** the detection cycle counts as bubble 1, so total bubbles = LOAD_BUBBLES. The held ID instruction re-enters EXM on cycle LOAD_BUBBLES+1.
- **Redirect:** total bubbled cycles = REDIRECT_FLUSH, starting in the redirect cycle.
- **mem_busy:** extends any LDSTALL/FLUSH by exactly the number of busy cycles; the bubble count is preserved.
- **Simultaneous redirect and use_haz:** redirect only; no load stall (the ID instruction is squashed).
- **rst mid-LDSTALL/FLUSH:** abandons the sequence; RUN on the next cycle.

## Configuration

- **PIPECTRL_PERF_EN defined:**
  - stall_cycles increments by 1 on every non-reset cycle in which pc_stall=1 or id_exm_bubble=1.
  - Saturates at 32'hFFFFFFFF; cleared by rst.
- **Undefined:** the stall_cycles port and counter are absent; all other behaviour is identical.

## Test plan

- **Load-use, rs2:** LOAD_BUBBLES=1, exm_inst=lw x5, id_inst=add x6,x1,x5 → pc_stall=if_id_stall=id_exm_bubble=1 for 1 cycle, then all 0.
- **No hazard from non-use:**
  - lw x5 in EXM, id_inst=lui x5 → no stall.
  - lw x0 in EXM → no stall.
- **Multi-bubble under freeze:** LOAD_BUBBLES=3, then mem_busy=1 for 2 cycles during bubble 2 → id_exm_bubble=1 on exactly 3 non-busy cycles, all four stalls=1 during busy; with PIPECTRL_PERF_EN, stall_cycles=5.
- **Redirect beats load-use:** REDIRECT_FLUSH=2, exm_redirect=1 with use_haz=1 → pc_redirect=1 for 1 cycle, id_exm_bubble=1 for 2 cycles, pc_stall=0 throughout.
- **Reset mid-sequence:** rst pulsed in the second LDSTALL cycle → next cycle state RUN, all outputs 0, stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, redirect flush and mem_busy freeze for a 3-stage RV32I core.
// Latency: zero-cycle; all control outputs are combinational from state, cnt and the current inputs.
// Backpressure: mem_busy freezes every stage and holds state/cnt; optional PIPECTRL_PERF_EN adds the stall_cycles counter.
module pipe_hazard_ctrl #(
  parameter int LOAD_BUBBLES   = 1,
  parameter int REDIRECT_FLUSH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic [31:0] exm_inst,
  input  logic        exm_reg_wen,
  input  logic        exm_is_load,
  input  logic        exm_redirect,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        pc_redirect,
  output logic        if_id_stall,
  output logic        id_exm_bubble,
  output logic        id_exm_stall,
  output logic        exm_wb_stall
`ifdef PIPECTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

  // The detection / redirect cycle is itself the first bubble, so the
  // counter reload covers the remaining bubbles minus one.
  localparam logic [2:0] LD_RELOAD = (LOAD_BUBBLES > 1)   ? 3'(LOAD_BUBBLES - 2)   : 3'd0;
  localparam logic [2:0] RD_RELOAD = (REDIRECT_FLUSH > 1) ? 3'(REDIRECT_FLUSH - 2) : 3'd0;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [4:0] opc;
  logic [4:0] rd;
  logic       rs1_used, rs2_used, use_haz;

  // Only the opcode, register fields and CSR funct3[2] matter here.
  logic unused_bits;
  assign unused_bits = ^{id_inst[31:25], id_inst[13:12], id_inst[1:0],
                         exm_inst[31:12], exm_inst[6:0]};

  assign opc = id_inst[6:2];
  assign rd  = exm_inst[11:7];

  // Source-register usage decode of the IF/ID instruction.
  always_comb begin
    rs1_used = !((opc == 5'b01101) || (opc == 5'b00101) || (opc == 5'b11011) ||
                 ((opc == 5'b11100) && id_inst[14]));
    rs2_used = (opc == 5'b11000) || (opc == 5'b01000) || (opc == 5'b01100);
    use_haz  = exm_is_load && exm_reg_wen && (rd != 5'd0) &&
               ((rs1_used && (id_inst[19:15] == rd)) ||
                (rs2_used && (id_inst[24:20] == rd)));
  end

  // State and bubble counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and stage controls; priority is rst > mem_busy > redirect > load-use.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_stall      = 1'b0;
    pc_redirect   = 1'b0;
    if_id_stall   = 1'b0;
    id_exm_bubble = 1'b0;
    id_exm_stall  = 1'b0;
    exm_wb_stall  = 1'b0;
    if (rst) begin
      id_exm_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_exm_stall = 1'b1;
      exm_wb_stall = 1'b1;
    end else if (exm_redirect) begin
      pc_redirect   = 1'b1;
      id_exm_bubble = 1'b1;
      state_nxt     = (REDIRECT_FLUSH > 1) ? FLUSH : RUN;
      cnt_nxt       = RD_RELOAD;
    end else begin
      case (state)
        RUN: begin
          if (use_haz) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exm_bubble = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_nxt = LDSTALL;
              cnt_nxt   = LD_RELOAD;
            end
          end
        end
        LDSTALL: begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_exm_bubble = 1'b1;
          if (cnt == 3'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
        FLUSH: begin
          id_exm_bubble = 1'b1;
          if (cnt == 3'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef PIPECTRL_PERF_EN
  // Saturating count of cycles that stalled the PC or bubbled EXM.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= 32'd0;
    else if ((pc_stall || id_exm_bubble) && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_inst, exm_inst;
  logic        exm_reg_wen, exm_is_load, exm_redirect, mem_busy;

  logic a_pcs, a_pcr, a_ifs, a_bub, a_ids, a_wbs;
  logic b_pcs, b_pcr, b_ifs, b_bub, b_ids, b_wbs;
  logic [5:0] oa, ob;

  int tests  = 0;
  int failed = 0;

  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_RS2 = 32'h00508333; // add x6,x1,x5
  localparam logic [31:0] ADD_RS1 = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD_X0  = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] LUI_X5  = 32'h000282B7; // lui x5 with bits[19:15]=5
  localparam logic [31:0] CSRWI   = 32'h0002D073; // csrrwi x0,0,5
  localparam logic [31:0] NOP     = 32'h00000013;

  // bit order: pc_stall, pc_redirect, if_id_stall, id_exm_bubble, id_exm_stall, exm_wb_stall
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_BUB   = 6'b000100;
  localparam logic [5:0] O_LD    = 6'b101100;
  localparam logic [5:0] O_BUSY  = 6'b101011;
  localparam logic [5:0] O_REDIR = 6'b010100;

  always #5 clk = ~clk;

`ifdef PIPECTRL_PERF_EN
  logic [31:0] a_sc, b_sc;
`endif

  pipe_hazard_ctrl #(.LOAD_BUBBLES(1), .REDIRECT_FLUSH(1)) dut_a (
    .clk(clk), .rst(rst), .id_inst(id_inst), .exm_inst(exm_inst),
    .exm_reg_wen(exm_reg_wen), .exm_is_load(exm_is_load),
    .exm_redirect(exm_redirect), .mem_busy(mem_busy),
    .pc_stall(a_pcs), .pc_redirect(a_pcr), .if_id_stall(a_ifs),
    .id_exm_bubble(a_bub), .id_exm_stall(a_ids), .exm_wb_stall(a_wbs)
`ifdef PIPECTRL_PERF_EN
    , .stall_cycles(a_sc)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_BUBBLES(3), .REDIRECT_FLUSH(2)) dut_b (
    .clk(clk), .rst(rst), .id_inst(id_inst), .exm_inst(exm_inst),
    .exm_reg_wen(exm_reg_wen), .exm_is_load(exm_is_load),
    .exm_redirect(exm_redirect), .mem_busy(mem_busy),
    .pc_stall(b_pcs), .pc_redirect(b_pcr), .if_id_stall(b_ifs),
    .id_exm_bubble(b_bub), .id_exm_stall(b_ids), .exm_wb_stall(b_wbs)
`ifdef PIPECTRL_PERF_EN
    , .stall_cycles(b_sc)
`endif
  );

  assign oa = {a_pcs, a_pcr, a_ifs, a_bub, a_ids, a_wbs};
  assign ob = {b_pcs, b_pcr, b_ifs, b_bub, b_ids, b_wbs};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1ns after the falling edge.
  task automatic step(input logic r, input logic [31:0] id, input logic [31:0] ex,
                      input logic ld, input logic wen, input logic redir, input logic busy);
    @(negedge clk);
    rst = r; id_inst = id; exm_inst = ex; exm_is_load = ld;
    exm_reg_wen = wen; exm_redirect = redir; mem_busy = busy;
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_inst = NOP; exm_inst = NOP;
    exm_reg_wen = 1'b0; exm_is_load = 1'b0; exm_redirect = 1'b0; mem_busy = 1'b0;

    // reset: only id_exm_bubble asserted
    do_reset();
    chk("rst_out_a", 32'(oa), 32'(O_BUB));
    chk("rst_out_b", 32'(ob), 32'(O_BUB));
    step(1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_a", 32'(oa), 32'(O_IDLE));
    chk("idle_b", 32'(ob), 32'(O_IDLE));
`ifdef PIPECTRL_PERF_EN
    chk("rst_sc_b", b_sc, 32'd0);
`endif

    // load-use on rs2, single bubble
    step(1'b0, ADD_RS2, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_rs2_a_c1", 32'(oa), 32'(O_LD));
    step(1'b0, ADD_RS2, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lu_rs2_a_c2", 32'(oa), 32'(O_IDLE));

    // non-use cases: no stall
    do_reset();
    step(1'b0, LUI_X5, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lui_a", 32'(oa), 32'(O_IDLE));
    chk("lui_b", 32'(ob), 32'(O_IDLE));
    step(1'b0, ADD_X0, LW_X0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lw_x0_b", 32'(ob), 32'(O_IDLE));
    step(1'b0, CSRWI, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("csri_b", 32'(ob), 32'(O_IDLE));
    step(1'b0, ADD_RS2, LW_X5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("nowen_b", 32'(ob), 32'(O_IDLE));
    step(1'b0, ADD_RS2, LW_X5, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("noload_b", 32'(ob), 32'(O_IDLE));

    // three bubbles with a 2-cycle freeze during bubble 2
    do_reset();
    step(1'b0, ADD_RS1, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mb_c1", 32'(ob), 32'(O_LD));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mb_busy1", 32'(ob), 32'(O_BUSY));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("mb_busy2", 32'(ob), 32'(O_BUSY));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mb_bub2", 32'(ob), 32'(O_LD));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mb_bub3", 32'(ob), 32'(O_LD));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mb_done", 32'(ob), 32'(O_IDLE));
`ifdef PIPECTRL_PERF_EN
    chk("mb_sc", b_sc, 32'd5);
`endif

    // redirect beats load-use
    do_reset();
    step(1'b0, ADD_RS1, LW_X5, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rd_c1_b", 32'(ob), 32'(O_REDIR));
    chk("rd_c1_a", 32'(oa), 32'(O_REDIR));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rd_c2_b", 32'(ob), 32'(O_BUB));
    chk("rd_c2_a", 32'(oa), 32'(O_IDLE));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rd_c3_b", 32'(ob), 32'(O_IDLE));

    // redirect arriving during LDSTALL restarts as a flush
    do_reset();
    step(1'b0, ADD_RS1, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ldrd_c1", 32'(ob), 32'(O_LD));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ldrd_c2", 32'(ob), 32'(O_REDIR));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ldrd_c3", 32'(ob), 32'(O_BUB));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ldrd_c4", 32'(ob), 32'(O_IDLE));

    // reset in the second LDSTALL cycle abandons the sequence
    do_reset();
    step(1'b0, ADD_RS1, LW_X5, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rm_c1", 32'(ob), 32'(O_LD));
    step(1'b1, ADD_RS1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rm_rst", 32'(ob), 32'(O_BUB));
    step(1'b0, ADD_RS1, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rm_after", 32'(ob), 32'(O_IDLE));
`ifdef PIPECTRL_PERF_EN
    chk("rm_sc", b_sc, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
